// File: rtl/memory_unit_if.sv
// memory_unit_if: CPU RAM bus (minus the shared data lines) and program loader handshake
//   ram_address/ram_read_en/ram_write_en : CPU word address and level strobes
//   load_start/load_valid/load_data/load_last : loader request and byte stream
//   load_ready/load_done/load_count : loader status back to the host
//   cpu_hold/bus_conflict : CPU stall while loading, sticky bus-misuse flag
interface memory_unit_if #(parameter int ADDR_W = 4, parameter int WIDTH = 8);
  logic [ADDR_W-1:0] ram_address;
  logic              ram_read_en;
  logic              ram_write_en;
  logic              load_start;
  logic              load_valid;
  logic [WIDTH-1:0]  load_data;
  logic              load_last;
  logic              load_ready;
  logic              load_done;
  logic [ADDR_W:0]   load_count;
  logic              cpu_hold;
  logic              bus_conflict;
  modport master (
    output ram_address, ram_read_en, ram_write_en, load_start, load_valid, load_data, load_last,
    input  load_ready, load_done, load_count, cpu_hold, bus_conflict
  );
  modport slave (
    input  ram_address, ram_read_en, ram_write_en, load_start, load_valid, load_data, load_last,
    output load_ready, load_done, load_count, cpu_hold, bus_conflict
  );
endinterface

// File: rtl/memory_unit.sv
// memory_unit: 16x8 unified program/data memory with a byte-wide program loader
//   clk      : rising-edge clock
//   rst      : asynchronous active-low reset, clears FSM and every word
//   bus      : memory_unit_if.slave, CPU strobes/address and loader handshake
//   ram_data : shared CPU data bus, driven only during a granted read
module memory_unit #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int WIDTH  = 8
) (
  input  logic             clk,
  input  logic             rst,
  memory_unit_if.slave     bus,
  inout  wire  [WIDTH-1:0] ram_data
);
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
  state_t            state, state_nx;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W:0]   count;
  logic              conflict, hold, accept, cpu_wr;
  assign accept = state == LOAD && bus.load_valid;
  assign cpu_wr = bus.ram_write_en && !hold;
  // write_en gates the driver combinationally so the CPU and memory never fight
  assign ram_data = (bus.ram_read_en && !bus.ram_write_en && !hold) ? mem[bus.ram_address] : 'z;
  assign bus.load_count   = count;
  assign bus.bus_conflict = conflict;
  assign bus.cpu_hold     = hold;
  // the unused encoding falls through to IDLE
  always_comb begin
    state_nx      = IDLE;
    hold          = state == LOAD || state == DONE;
    bus.load_ready = state == LOAD;
    bus.load_done  = state == DONE;
    if (state == IDLE) state_nx = bus.load_start ? LOAD : IDLE;
    if (state == LOAD) state_nx = (accept && (bus.load_last || ptr == ADDR_W'(DEPTH - 1))) ? DONE : LOAD;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state    <= IDLE;
      ptr      <= '0;
      count    <= '0;
      conflict <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && bus.load_start) begin
        ptr   <= '0;
        count <= '0;
      end
      if (accept) begin
        mem[ptr] <= bus.load_data;
        ptr      <= ptr + 1;
        count    <= count + 1;
      end
      if (cpu_wr) mem[bus.ram_address] <= ram_data;
      if ((bus.ram_read_en && bus.ram_write_en) || (bus.ram_write_en && hold) || (bus.load_start && state == LOAD))
        conflict <= 1'b1;
    end
endmodule

// File: tb/tb_memory_unit.sv
// tb_memory_unit: directed self-checking bench for memory_unit
module tb_memory_unit;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tb_drv = 1'b0;
  logic [7:0] tb_data = 8'h00;
  wire  [7:0] ram_data;
  int         checks = 0;
  int         errors = 0;
  memory_unit_if bus ();
  memory_unit dut (.clk(clk), .rst(rst), .bus(bus), .ram_data(ram_data));
  assign ram_data = tb_drv ? tb_data : 8'hzz;
  always #5 clk = ~clk;
  task automatic idle_inputs();
    bus.ram_address = '0; bus.ram_read_en = 1'b0; bus.ram_write_en = 1'b0;
    bus.load_start = 1'b0; bus.load_valid = 1'b0; bus.load_data = '0; bus.load_last = 1'b0;
    tb_drv = 1'b0;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic reset_dut();
    idle_inputs();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask
  task automatic read_word(input logic [3:0] a, output logic [7:0] d);
    bus.ram_address = a; bus.ram_read_en = 1'b1; tb_drv = 1'b0;
    #1 d = ram_data;
    bus.ram_read_en = 1'b0;
  endtask
  task automatic start_load();
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
  endtask
  task automatic test_reset();
    logic [7:0] d;
    idle_inputs();
    rst = 1'b0;
    #3;
    checks++; if ({bus.load_ready, bus.load_done, bus.cpu_hold, bus.bus_conflict} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b expected 0000", {bus.load_ready, bus.load_done, bus.cpu_hold, bus.bus_conflict}); end
    checks++; if (bus.load_count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", bus.load_count); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    tb_drv = 1'b1; tb_data = 8'hC3;
    #1;
    checks++; if (ram_data !== 8'hC3) begin errors++; $display("FAIL reset_bus_released: got %h expected c3", ram_data); end
    tb_drv = 1'b0;
    for (int i = 0; i < 16; i++) begin
      read_word(4'(i), d);
      checks++; if (d !== 8'h00) begin errors++; $display("FAIL reset_mem[%0d]: got %h expected 00", i, d); end
    end
  endtask
  task automatic test_load4();
    logic [7:0] img [4] = '{8'h2E, 8'h1F, 8'h80, 8'h00};
    logic [7:0] d;
    start_load();
    checks++; if ({bus.cpu_hold, bus.load_ready, bus.load_count} !== {2'b11, 5'd0}) begin errors++; $display("FAIL load4_enter: got hold=%b ready=%b count=%0d expected 1 1 0", bus.cpu_hold, bus.load_ready, bus.load_count); end
    for (int i = 0; i < 4; i++) begin
      bus.load_valid = 1'b1; bus.load_data = img[i]; bus.load_last = (i == 3);
      tick();
      checks++; if (bus.load_count !== 5'(i + 1)) begin errors++; $display("FAIL load4_count%0d: got %0d expected %0d", i, bus.load_count, i + 1); end
    end
    bus.load_valid = 1'b0; bus.load_last = 1'b0;
    checks++; if ({bus.load_done, bus.load_ready, bus.cpu_hold} !== 3'b101) begin errors++; $display("FAIL load4_done: got done/ready/hold=%b expected 101", {bus.load_done, bus.load_ready, bus.cpu_hold}); end
    tick();
    checks++; if ({bus.load_done, bus.cpu_hold, bus.load_count} !== {2'b00, 5'd4}) begin errors++; $display("FAIL load4_idle: got done=%b hold=%b count=%0d expected 0 0 4", bus.load_done, bus.cpu_hold, bus.load_count); end
    for (int i = 0; i < 4; i++) begin
      read_word(4'(i), d);
      checks++; if (d !== img[i]) begin errors++; $display("FAIL load4_read[%0d]: got %h expected %h", i, d, img[i]); end
    end
  endtask
  task automatic test_load20();
    logic [7:0] d;
    start_load();
    bus.load_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.load_data = 8'(8'h10 + i);
      tick();
      if (i < 15) begin
        checks++; if ({bus.load_ready, bus.load_count} !== {1'b1, 5'(i + 1)}) begin errors++; $display("FAIL load20_step%0d: got ready=%b count=%0d expected 1 %0d", i, bus.load_ready, bus.load_count, i + 1); end
      end else if (i == 15) begin
        checks++; if ({bus.load_ready, bus.load_done, bus.load_count} !== {2'b01, 5'd16}) begin errors++; $display("FAIL load20_full: got ready=%b done=%b count=%0d expected 0 1 16", bus.load_ready, bus.load_done, bus.load_count); end
      end else begin
        checks++; if ({bus.load_ready, bus.cpu_hold, bus.load_count} !== {2'b00, 5'd16}) begin errors++; $display("FAIL load20_after%0d: got ready=%b hold=%b count=%0d expected 0 0 16", i, bus.load_ready, bus.cpu_hold, bus.load_count); end
      end
    end
    bus.load_valid = 1'b0;
    read_word(4'h0, d);
    checks++; if (d !== 8'h10) begin errors++; $display("FAIL load20_nowrap: got %h expected 10", d); end
    read_word(4'hF, d);
    checks++; if (d !== 8'h1F) begin errors++; $display("FAIL load20_last: got %h expected 1f", d); end
  endtask
  task automatic test_cpu_write();
    logic [7:0] d;
    bus.ram_address = 4'hE; bus.ram_write_en = 1'b1; tb_drv = 1'b1; tb_data = 8'h5A;
    tick();
    bus.ram_write_en = 1'b0; tb_drv = 1'b0;
    read_word(4'hE, d);
    checks++; if (d !== 8'h5A) begin errors++; $display("FAIL cpu_write_read: got %h expected 5a", d); end
    checks++; if (bus.bus_conflict !== 1'b0) begin errors++; $display("FAIL cpu_write_noconflict: got %b expected 0", bus.bus_conflict); end
    bus.ram_address = 4'hE; bus.ram_read_en = 1'b1; bus.ram_write_en = 1'b1; tb_drv = 1'b1; tb_data = 8'hA5;
    #1;
    checks++; if (ram_data !== 8'hA5) begin errors++; $display("FAIL rw_release: got %h expected a5", ram_data); end
    tick();
    idle_inputs();
    checks++; if (bus.bus_conflict !== 1'b1) begin errors++; $display("FAIL rw_conflict: got %b expected 1", bus.bus_conflict); end
    read_word(4'hE, d);
    checks++; if (d !== 8'hA5) begin errors++; $display("FAIL rw_write_done: got %h expected a5", d); end
  endtask
  task automatic test_write_during_load();
    logic [7:0] d;
    reset_dut();
    start_load();
    bus.ram_address = 4'h9; bus.ram_write_en = 1'b1; tb_drv = 1'b1; tb_data = 8'h77;
    tick();
    bus.ram_write_en = 1'b0; tb_drv = 1'b0;
    checks++; if (bus.bus_conflict !== 1'b1) begin errors++; $display("FAIL held_write_conflict: got %b expected 1", bus.bus_conflict); end
    bus.load_valid = 1'b1; bus.load_data = 8'h33; bus.load_last = 1'b1;
    tick();
    idle_inputs();
    tick();
    read_word(4'h9, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL held_write_dropped: got %h expected 00", d); end
    read_word(4'h0, d);
    checks++; if (d !== 8'h33) begin errors++; $display("FAIL held_write_load: got %h expected 33", d); end
  endtask
  task automatic test_restart_in_load();
    logic [7:0] d;
    reset_dut();
    start_load();
    bus.load_valid = 1'b1; bus.load_data = 8'h11;
    tick();
    bus.load_start = 1'b1; bus.load_data = 8'h22;
    tick();
    bus.load_start = 1'b0;
    checks++; if ({bus.bus_conflict, bus.load_ready, bus.load_count} !== {2'b11, 5'd2}) begin errors++; $display("FAIL restart_ignored: got conflict=%b ready=%b count=%0d expected 1 1 2", bus.bus_conflict, bus.load_ready, bus.load_count); end
    bus.load_data = 8'h33; bus.load_last = 1'b1;
    tick();
    idle_inputs();
    tick();
    checks++; if (bus.load_count !== 5'd3) begin errors++; $display("FAIL restart_count: got %0d expected 3", bus.load_count); end
    read_word(4'h1, d);
    checks++; if (d !== 8'h22) begin errors++; $display("FAIL restart_mem1: got %h expected 22", d); end
  endtask
  task automatic test_reset_mid_load();
    logic [7:0] d;
    reset_dut();
    start_load();
    bus.load_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.load_data = 8'(8'hAA + i);
      tick();
    end
    bus.load_valid = 1'b0;
    checks++; if (bus.load_count !== 5'd3) begin errors++; $display("FAIL midload_count_pre: got %0d expected 3", bus.load_count); end
    #2 rst = 1'b0;
    #1;
    checks++; if ({bus.cpu_hold, bus.load_ready, bus.load_count} !== {2'b00, 5'd0}) begin errors++; $display("FAIL midload_reset: got hold=%b ready=%b count=%0d expected 0 0 0", bus.cpu_hold, bus.load_ready, bus.load_count); end
    tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      read_word(4'(i), d);
      checks++; if (d !== 8'h00) begin errors++; $display("FAIL midload_mem[%0d]: got %h expected 00", i, d); end
    end
  endtask
  initial begin
    test_reset();
    test_load4();
    test_load20();
    test_cpu_write();
    test_write_during_load();
    test_restart_in_load();
    test_reset_mid_load();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
